// File: rtl/order_stream_mux.sv
// Packet-level round-robin multiplexer: N upstream order streams onto one output stream.
// A stream is locked in for a whole packet, so beats from different packets never interleave.
module order_stream_mux #(
    parameter int N  = 3,
    parameter int W  = 64,
    parameter int CW = 32,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SW-1:0]  out_src,
    input  logic           out_ready,
    output logic           busy,
    output logic [CW-1:0]  pkt_count
);

    // Handshake: a beat moves on any port exactly on a rising edge where valid and
    // ready are both 1; valid never waits for ready, ready never looks at valid.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [N-1:0]  winner;
    logic          found;
    logic          past_ptr;
    logic          can_take;
    logic          accept;
    logic          last_accept;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic [SW-1:0] sel_src;

    assign busy        = (state_q == LOCKED);
    assign can_take    = !out_valid || out_ready;
    assign in_ready    = (busy && can_take) ? gnt_q : '0;
    assign accept      = |(in_valid & in_ready);
    assign last_accept = accept && sel_last;

    // Round-robin pick: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        past_ptr = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) past_ptr = 1'b1;
            if (past_ptr && in_valid[i] && !found) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_src  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
                sel_src  = SW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    state_d = LOCKED;
                    gnt_d   = winner;
                end
            end
            LOCKED: begin
                if (last_accept) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = {gnt_q[N-2:0], gnt_q[N-1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= N'(1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            pkt_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= sel_src;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (last_accept) pkt_count <= pkt_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_order_stream_mux.sv
// Bench for order_stream_mux: per-stream packet queues feed the inputs, and every
// expected output beat {src,last,data} is queued in predicted arbitration order.
module tb_order_stream_mux;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int SW = 2;
    localparam int EW = SW + 1 + W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready = 1'b1;
    logic           busy;
    logic [CW-1:0]  pkt_count;

    int             n_checks = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             exp_pkts = 0;
    int             out_cyc[$];
    logic [EW-1:0]  exp_q[$];
    logic [W:0]     sq[N][$];
    logic [N-1:0]   hold = '0;

    order_stream_mux #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Driver: presents each stream's head beat; retires it after a handshake.
    initial begin
        logic [N-1:0] fire;
        logic [W:0]   h;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    h = sq[i][0];
                    in_valid[i] = !hold[i];
                    in_data[i*W +: W] = h[W-1:0];
                    in_last[i] = h[W];
                end else begin
                    in_valid[i] = 1'b0;
                    in_data[i*W +: W] = '0;
                    in_last[i] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every output transfer must match the head of the expected queue.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_beat: got src=%0d last=%0b data=%h, expected no beat",
                             out_src, out_last, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_src, out_last, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL out_beat: got src=%0d last=%0b data=%h, expected src=%0d last=%0b data=%h",
                                 out_src, out_last, out_data, e[EW-1 -: SW], e[W], e[W-1:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pkt(input int s, input int nbeats, input logic [W-1:0] base);
        for (int b = 0; b < nbeats; b++) begin
            sq[s].push_back({(b == nbeats - 1), base + W'(b)});
            exp_q.push_back({SW'(s), (b == nbeats - 1), base + W'(b)});
        end
        exp_pkts++;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 50);
        if (!busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_busy_timeout: busy=%0b after %0d cycles, expected 1", name, busy, n);
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int  n;
        bit  idle;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            idle = (exp_q.size() == 0) && !busy && !out_valid;
            for (int i = 0; i < N; i++) if (sq[i].size() != 0) idle = 0;
        end while (!idle && n < limit);
        if (!idle) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain_timeout: %0d expected beats left after %0d cycles, expected 0",
                     name, exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_flags: got valid=%b last=%b, expected 0 0", out_valid, out_last);
        end
        n_checks++;
        if (out_data !== '0 || out_src !== '0) begin
            n_fail++;
            $display("FAIL reset_out_regs: got data=%h src=%0d, expected 0 0", out_data, out_src);
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_handshake: got busy=%b in_ready=%b, expected 0 000", busy, in_ready);
        end
        n_checks++;
        if (pkt_count !== '0) begin
            n_fail++;
            $display("FAIL reset_pkt_count: got %0d, expected 0", pkt_count);
        end
        tick();
        rst_n = 1'b1;
        exp_pkts = 0;
    endtask

    task automatic test_round_robin();
        out_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) send_pkt(s, 1, W'(16'h0100 + r * 16 + s));
        wait_drain("round_robin", 200);
        n_checks++;
        if (out_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL rr_beats: got %0d output beats, expected 6", out_cyc.size());
        end else begin
            for (int k = 1; k < 6; k++) begin
                n_checks++;
                if (out_cyc[k] - out_cyc[k-1] != 2) begin
                    n_fail++;
                    $display("FAIL rr_gap: beat %0d gap got %0d cycles, expected 2",
                             k, out_cyc[k] - out_cyc[k-1]);
                end
            end
        end
        n_checks++;
        if (pkt_count !== CW'(exp_pkts)) begin
            n_fail++;
            $display("FAIL rr_pkt_count: got %0d, expected %0d", pkt_count, CW'(exp_pkts));
        end
    endtask

    task automatic test_latency();
        send_pkt(1, 1, 16'h0A00);
        @(posedge clk);
        #3;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL lat_idle: got busy=%b in_ready=%b, expected 0 000", busy, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 3'b010 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_locked: got busy=%b in_ready=%b out_valid=%b, expected 1 010 0",
                     busy, in_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            n_fail++;
            $display("FAIL lat_out: got out_valid=%b src=%0d, expected 1 1", out_valid, out_src);
        end
        wait_drain("latency", 50);
        n_checks++;
        if (pkt_count !== CW'(exp_pkts)) begin
            n_fail++;
            $display("FAIL lat_pkt_count: got %0d, expected %0d", pkt_count, CW'(exp_pkts));
        end
    endtask

    task automatic test_long_packet();
        out_cyc.delete();
        send_pkt(1, 4, 16'h0010);
        wait_busy("long");
        send_pkt(0, 1, 16'h00B0);
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL long_lock: got in_ready[0]=%b busy=%b, expected 0 1", in_ready[0], busy);
            end
        end
        wait_drain("long", 100);
        n_checks++;
        if (out_cyc.size() != 5) begin
            n_fail++;
            $display("FAIL long_beats: got %0d output beats, expected 5", out_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (out_cyc[k] - out_cyc[k-1] != 1) begin
                    n_fail++;
                    $display("FAIL long_throughput: beat %0d gap got %0d cycles, expected 1",
                             k, out_cyc[k] - out_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] held;
        int n;
        send_pkt(2, 4, 16'h0020);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        tick();
        out_ready = 1'b0;
        held = exp_q[0];
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held[W-1:0] || in_ready[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: got valid=%b data=%h in_ready[2]=%b, expected 1 %h 0",
                         out_valid, out_data, in_ready[2], held[W-1:0]);
            end
        end
        tick();
        out_ready = 1'b1;
        wait_drain("backpressure", 100);
        n_checks++;
        if (pkt_count !== CW'(exp_pkts)) begin
            n_fail++;
            $display("FAIL bp_pkt_count: got %0d, expected %0d", pkt_count, CW'(exp_pkts));
        end
    endtask

    task automatic test_drop_valid();
        int n;
        send_pkt(0, 4, 16'h0030);
        wait_busy("drop");
        n = 0;
        while (sq[0].size() > 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        hold[0] = 1'b1;
        send_pkt(2, 1, 16'h0040);
        tick();
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || in_ready[2] !== 1'b0 || out_valid === 1'b1 && out_src === 2'd2) begin
                n_fail++;
                $display("FAIL drop_hold: got busy=%b in_ready[2]=%b out_src=%0d, expected 1 0 not 2",
                         busy, in_ready[2], out_src);
            end
        end
        hold[0] = 1'b0;
        wait_drain("drop", 100);
    endtask

    task automatic test_reset_mid();
        int n;
        send_pkt(1, 1, 16'h0050);
        wait_drain("rst_prelude", 50);
        out_cyc.delete();
        send_pkt(1, 4, 16'h0060);
        n = 0;
        while (out_cyc.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, out_data, out_src} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_out: got valid=%b last=%b data=%h src=%0d, expected all 0",
                     out_valid, out_last, out_data, out_src);
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== '0 || pkt_count !== '0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got busy=%b in_ready=%b pkt_count=%0d, expected 0 000 0",
                     busy, in_ready, pkt_count);
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_pkts = 0;
        send_pkt(1, 1, 16'h0071);
        send_pkt(2, 1, 16'h0072);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_drain("rstmid", 100);
        n_checks++;
        if (pkt_count !== CW'(exp_pkts)) begin
            n_fail++;
            $display("FAIL rstmid_pkt_count: got %0d, expected %0d", pkt_count, CW'(exp_pkts));
        end
    endtask

    task automatic test_ptr_wrap();
        send_pkt(2, 1, 16'h0080);
        wait_busy("wrap");
        send_pkt(0, 1, 16'h0081);
        send_pkt(1, 1, 16'h0082);
        wait_drain("wrap", 100);
    endtask

    task automatic test_count_wrap();
        for (int k = 0; k < 256; k++) send_pkt(0, 1, W'(k));
        wait_drain("count_wrap", 3000);
        n_checks++;
        if (pkt_count !== CW'(exp_pkts)) begin
            n_fail++;
            $display("FAIL count_wrap: got %0d, expected %0d", pkt_count, CW'(exp_pkts));
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_long_packet();
        test_backpressure();
        test_drop_valid();
        test_reset_mid();
        test_ptr_wrap();
        test_count_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d beats outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/order_stream_mux.md
ORDER_STREAM_MUX -- requirements
Module: order_stream_mux

Interface
REQ-001 Parameter N, default 3, number of upstream order streams (N >= 2).
REQ-002 Parameter W, default 64, data beat width in bits.
REQ-003 Parameter CW, default 32, packet counter width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  N  per-stream beat valid; bit i belongs to stream i.
REQ-007 in_data  input  N*W  per-stream beat data; stream i occupies bits [i*W +: W].
REQ-008 in_last  input  N  per-stream end-of-packet marker.
REQ-009 in_ready  output  N  per-stream beat accept; a beat transfers when in_valid[i] and in_ready[i] are both 1.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data  output  W  output beat data.
REQ-012 out_last  output  1  output end-of-packet marker.
REQ-013 out_src  output  max(1,$clog2(N))  index of the stream that produced the output beat.
REQ-014 out_ready  input  1  downstream accept; an output beat transfers when out_valid and out_ready are both 1.
REQ-015 busy  output  1  1 while in LOCKED state.
REQ-016 pkt_count  output  CW  count of packets fully accepted from upstream, wraps modulo 2^CW.

Function
REQ-017 FSM states: IDLE, LOCKED; one-hot grant register gnt[N-1:0]; one-hot priority pointer ptr[N-1:0].
REQ-018 IDLE: if any in_valid bit is 1, the block SHALL load gnt with the round-robin winner and enter LOCKED on the next edge; otherwise remain IDLE.
REQ-019 Winner: lowest-index requesting stream with index >= index of ptr; if none, lowest-index requesting stream overall.
REQ-020 in_ready SHALL be 0 for every stream in IDLE and for every non-granted stream in LOCKED.
REQ-021 LOCKED: in_ready[g] = (out_valid == 0) or out_ready, where g is the granted stream; in_ready is combinational from these terms only, never from in_valid.
REQ-022 An accepted beat SHALL be registered into out_data/out_last/out_src with out_valid = 1 on the next edge.
REQ-023 out_valid SHALL clear on an edge where out_ready = 1 and no new beat is accepted; output registers SHALL hold while out_valid = 1 and out_ready = 0.
REQ-024 Accepting a beat with in_last = 1 in LOCKED: next state IDLE, gnt cleared, ptr <= gnt rotated left by one (bit N-1 wraps to bit 0), pkt_count increments.
REQ-025 ptr and gnt SHALL NOT change on any other cycle.
REQ-026 Granted stream dropping in_valid mid-packet: remain LOCKED, no transfer, no stream switch, no timeout.
REQ-027 Latency: in_valid asserted in IDLE at edge t -> LOCKED at t+1 -> first beat accepted in cycle t+1 if output register free -> out_valid at t+2.
REQ-028 Back-to-back packets: one IDLE arbitration cycle between the last beat of one packet and the first beat of the next.
REQ-029 Beat order within a packet SHALL be preserved; beats from different packets SHALL never interleave.
REQ-030 Throughput in LOCKED with out_ready held 1 and in_valid held 1: one beat per cycle.

Reset
REQ-031 On rst_n = 0, immediately: state IDLE, gnt = 0, ptr = 1 (stream 0 highest priority), out_valid = 0, out_last = 0, out_data = 0, out_src = 0, pkt_count = 0, busy = 0, in_ready = 0.
REQ-032 Reset mid-packet discards the partial packet; after release, arbitration restarts from ptr = 1.

Verification
REQ-033 N=3, all in_valid = 111, each stream a 1-beat packet, out_ready = 1 -> out_src sequence 0,1,2,0,... with one idle cycle between beats; pkt_count increments by 1 per packet.
REQ-034 Stream 1 sends a 4-beat packet (data 0x10..0x13) while stream 0 requests -> output 0x10,0x11,0x12,0x13 with out_src = 1 and no interleaving; stream 0 granted next.
REQ-035 out_ready = 0 for 5 cycles during a packet -> out_data stable, out_valid = 1, in_ready[g] = 0; resuming yields no lost or duplicated beats.
REQ-036 Granted stream drops in_valid for 3 cycles mid-packet while stream 2 requests -> busy stays 1, no beat from stream 2 until granted stream's last beat.
REQ-037 Reset asserted after beat 2 of a 4-beat packet -> all outputs at REQ-031 values; first grant after release goes to lowest-index requester.
REQ-038 ptr wrap: stream 2 wins, then only streams 0 and 1 request -> stream 0 granted next.
